// File: rtl/seg7_scan_driver_if.sv
// Interface between the stopwatch counters and the 7-segment scan driver:
// six BCD digits in, shared segment bus and digit enables out.
interface seg7_scan_driver_if;
  logic [3:0] hr_h;
  logic [3:0] hr_l;
  logic [3:0] min_h;
  logic [3:0] min_l;
  logic [3:0] sec_h;
  logic [3:0] sec_l;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;

  modport master (
    output hr_h, hr_l, min_h, min_l, sec_h, sec_l,
    input  seg, dp, an
  );

  modport slave (
    input  hr_h, hr_l, min_h, min_l, sec_h, sec_l,
    output seg, dp, an
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Six-digit multiplexed 7-segment driver with per-frame digit snapshot and anti-ghost blanking.
// Optional macro LEAD_ZERO_BLANK_EN suppresses leading zeros on the hours digits.
module seg7_scan_driver #(
  parameter logic [15:0] SCAN_DIV       = 16'd50000,
  parameter logic [15:0] GHOST_CYC      = 16'd500,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  seg7_scan_driver_if.slave bus
);

  function automatic logic [6:0] dec7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  function automatic logic [6:0] seg_pol(input logic [6:0] s);
    return SEG_ACTIVE_LOW ? ~s : s;
  endfunction

  function automatic logic dp_pol(input logic d);
    return SEG_ACTIVE_LOW ? ~d : d;
  endfunction

  function automatic logic [5:0] an_pol(input logic [5:0] a);
    return AN_ACTIVE_LOW ? ~a : a;
  endfunction

  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [5:0] AN_OFF  = AN_ACTIVE_LOW ? 6'h3F : 6'h00;

  logic [15:0]     pcnt_q, pcnt_d;
  logic [2:0]      idx_q, idx_d;
  // snap_q[5] = hr_h ... snap_q[0] = sec_l, matching the an[] ordering
  logic [5:0][3:0] snap_q, snap_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic [5:0]      an_q, an_d;

  logic       slot_end;
  logic       idx_valid;
  logic       blank;
  logic       digit_blank;
  logic [3:0] digit;
  logic [6:0] seg_raw;
  logic       dp_raw;
  logic [5:0] an_raw;

  always_comb begin
    slot_end  = (pcnt_q == SCAN_DIV - 16'd1);
    idx_valid = (idx_q <= 3'd5);

    pcnt_d = slot_end ? 16'd0 : pcnt_q + 16'd1;
    idx_d  = idx_q;
    if (!idx_valid) begin
      idx_d  = 3'd0;
      pcnt_d = 16'd0;
    end else if (slot_end) begin
      idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end

    // Load all six digits together at the frame boundary so a frame never mixes counts
    snap_d = snap_q;
    if (slot_end && idx_q == 3'd5) begin
      snap_d = {bus.hr_h, bus.hr_l, bus.min_h, bus.min_l, bus.sec_h, bus.sec_l};
    end

    digit  = 4'd0;
    an_raw = 6'b000000;
    case (idx_q)
      3'd0: begin digit = snap_q[5]; an_raw = 6'b100000; end
      3'd1: begin digit = snap_q[4]; an_raw = 6'b010000; end
      3'd2: begin digit = snap_q[3]; an_raw = 6'b001000; end
      3'd3: begin digit = snap_q[2]; an_raw = 6'b000100; end
      3'd4: begin digit = snap_q[1]; an_raw = 6'b000010; end
      3'd5: begin digit = snap_q[0]; an_raw = 6'b000001; end
      default: begin digit = 4'd0; an_raw = 6'b000000; end
    endcase

    digit_blank = 1'b0;
`ifdef LEAD_ZERO_BLANK_EN
    if (idx_q == 3'd0 && snap_q[5] == 4'd0) digit_blank = 1'b1;
    if (idx_q == 3'd1 && snap_q[5] == 4'd0 && snap_q[4] == 4'd0) digit_blank = 1'b1;
`endif

    seg_raw = digit_blank ? 7'h00 : dec7(digit);
    dp_raw  = (idx_q == 3'd1) || (idx_q == 3'd3);
    blank   = (pcnt_q < GHOST_CYC) || !idx_valid;

    if (blank) begin
      seg_d = SEG_OFF;
      dp_d  = DP_OFF;
      an_d  = AN_OFF;
    end else begin
      seg_d = seg_pol(seg_raw);
      dp_d  = dp_pol(dp_raw);
      an_d  = an_pol(an_raw);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pcnt_q <= 16'd0;
      idx_q  <= 3'd0;
      snap_q <= '0;
      seg_q  <= SEG_OFF;
      dp_q   <= DP_OFF;
      an_q   <= AN_OFF;
    end else begin
      pcnt_q <= pcnt_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      an_q   <= an_d;
    end
  end

  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;
  assign bus.an  = an_q;

endmodule
